// File: rtl/input_cond_pkg.sv
// Shared types and constants for the input conditioner.
// Optional auto-repeat is built only when INPUT_COND_AUTOREPEAT_EN is defined.
package input_cond_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    RELEASED = 3'd3,
    COOLDOWN = 3'd4
  } cond_state_t;

  localparam logic [22:0] DEBOUNCE_LIMIT_FPGA = 23'd6_250_000;

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned input: synchroniser, press/release FSM and lockout counter.
// Auto-repeat pulses in HELD exist only when INPUT_COND_AUTOREPEAT_EN is defined.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 23
`ifdef INPUT_COND_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 6_250_000
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw_in,
  input  logic [CNT_W-1:0] debounce_limit,
  output logic             level,
  output logic             press,
  output logic             release_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  cond_state_t            state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s, cnt_inc_s;
  logic                   lock_done_s;
  logic                   press_s;
  logic                   level_r, press_r, release_r;

  // synchroniser shift chain
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s_s         = sync_r[SYNC_STAGES-1];
  // lowering the limit below the running count ends the lockout at once
  assign lock_done_s = (cnt_r >= debounce_limit);
  assign cnt_inc_s   = lock_done_s ? debounce_limit : (cnt_r + CNT_W'(1));

  // next-state and lockout counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (s_s) state_s = PRESSED;
        else     state_s = IDLE;
      end
      PRESSED: begin
        cnt_s   = '0;
        state_s = HELD;
      end
      HELD: begin
        cnt_s = cnt_inc_s;
        if (!s_s && lock_done_s) state_s = RELEASED;
        else                     state_s = HELD;
      end
      RELEASED: begin
        cnt_s   = '0;
        state_s = COOLDOWN;
      end
      COOLDOWN: begin
        cnt_s = cnt_inc_s;
        if (lock_done_s) state_s = IDLE;
        else             state_s = COOLDOWN;
      end
      default: begin
        cnt_s   = '0;
        state_s = IDLE;
      end
    endcase
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  logic [31:0] rpt_r, rpt_s;

  // repeat down-counter: value 1 in HELD means a repeat pulse next cycle
  always_comb begin
    rpt_s = 32'd0;
    if (state_r == PRESSED) begin
      rpt_s = 32'(REPEAT_DELAY - 1);
    end else if ((state_r == HELD) && (state_s == HELD)) begin
      if (rpt_r == 32'd1) rpt_s = 32'(REPEAT_PERIOD);
      else                rpt_s = rpt_r - 32'd1;
    end else begin
      rpt_s = 32'd0;
    end
  end

  // repeat counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      rpt_r <= 32'd0;
    end else begin
      rpt_r <= rpt_s;
    end
  end

  assign press_s = (state_s == PRESSED) ||
                   ((state_r == HELD) && (state_s == HELD) && s_s && (rpt_r == 32'd1));
`else
  assign press_s = (state_s == PRESSED);
`endif

  // state, counter and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      level_r   <= (state_s == PRESSED) || (state_s == HELD);
      press_r   <= press_s;
      release_r <= (state_s == RELEASED);
    end
  end

  assign level         = level_r;
  assign press         = press_r;
  assign release_pulse = release_r;

endmodule

// File: rtl/input_conditioner.sv
// N-channel button/switch front end: per-channel conditioning plus a combined press flag.
// Define INPUT_COND_AUTOREPEAT_EN to enable auto-repeat press pulses while held.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_CH      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 23
`ifdef INPUT_COND_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 6_250_000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [CNT_W-1:0]  debounce_limit,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse,
  output logic              any_press
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .CNT_W         (CNT_W)
`ifdef INPUT_COND_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clock          (clock),
      .reset          (reset),
      .raw_in         (raw_in[i]),
      .debounce_limit (debounce_limit),
      .level          (level[i]),
      .press          (press[i]),
      .release_pulse  (release_pulse[i])
    );
  end

  // press bits are already registered, so this stays aligned with them
  assign any_press = |press;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and random stimulus for input_conditioner against a timing-rule reference model.
// Define INPUT_COND_AUTOREPEAT_EN to also exercise auto-repeat (delay 20, period 5).
module tb_input_conditioner;

  localparam int NUM_CH      = 12;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 23;
  localparam int HIST        = 4096;
`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int R_DELAY  = 20;
  localparam int R_PERIOD = 5;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] raw_in;
  logic [CNT_W-1:0]  debounce_limit;
  logic [NUM_CH-1:0] level, press, release_pulse;
  logic              any_press;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [NUM_CH-1:0] raw_h [HIST];
  bit                rst_h [HIST];
  bit                lvl   [NUM_CH];
  int                prs_t [NUM_CH];
  int                rel_t [NUM_CH];
  int                np    [NUM_CH];
  int                nr    [NUM_CH];
  logic [NUM_CH-1:0] exp_level, exp_press, exp_rel;

  input_conditioner #(
    .NUM_CH        (NUM_CH),
    .SYNC_STAGES   (SYNC_STAGES),
    .CNT_W         (CNT_W)
`ifdef INPUT_COND_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY  (R_DELAY),
    .REPEAT_PERIOD (R_PERIOD)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .raw_in         (raw_in),
    .debounce_limit (debounce_limit),
    .level          (level),
    .press          (press),
    .release_pulse  (release_pulse),
    .any_press      (any_press)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      np[c] = 0;
      nr[c] = 0;
    end
  endtask

  // One clock: record inputs, advance, predict from timing rules, compare.
  // s seen in cycle n is raw from cycle n-2 unless a reset edge cleared the chain.
  // Press accepted when idle and at least L+2 cycles after the last release;
  // release accepted when s is low and at least L+1 cycles after the press.
  task automatic step();
    int   n;
    int   lim;
    int   k;
    logic s;
    logic first;
    n          = cyc;
    lim        = int'(debounce_limit);
    raw_h[n]   = raw_in;
    rst_h[n]   = reset;
    @(posedge clock);
    cyc++;
    #1;
    if (!rst_h[n]) begin
      exp_level = '0;
      exp_press = '0;
      exp_rel   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        lvl[c]   = 1'b0;
        prs_t[c] = -1000;
        rel_t[c] = -1000;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        s = (n >= 2) ? (raw_h[n-2][c] & rst_h[n-2] & rst_h[n-1]) : 1'b0;
        first        = !lvl[c] && s && (n >= rel_t[c] + lim + 2);
        exp_press[c] = first;
        exp_rel[c]   = lvl[c] && !s && (n >= prs_t[c] + lim + 1);
`ifdef INPUT_COND_AUTOREPEAT_EN
        k = n + 1 - prs_t[c];
        if (lvl[c] && s && (k >= R_DELAY) && (((k - R_DELAY) % R_PERIOD) == 0))
          exp_press[c] = 1'b1;
`else
        k = 0;
`endif
        if (first) begin
          lvl[c]   = 1'b1;
          prs_t[c] = n + 1;
        end
        if (exp_rel[c]) begin
          lvl[c]   = 1'b0;
          rel_t[c] = n + 1;
        end
        exp_level[c] = lvl[c];
      end
    end
    check("level", 32'(level), 32'(exp_level));
    check("press", 32'(press), 32'(exp_press));
    check("release", 32'(release_pulse), 32'(exp_rel));
    check("any_press", 32'(any_press), 32'(|exp_press));
    check("press_and_release", 32'(press & release_pulse), 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (press[c] === 1'b1)         np[c]++;
      if (release_pulse[c] === 1'b1) nr[c]++;
    end
  endtask

  task automatic settle();
    raw_in = '0;
    repeat (30) step();
  endtask

  initial begin
    // reset held with all inputs high
    reset          = 1'b0;
    raw_in         = '1;
    debounce_limit = 23'd0;
    repeat (3) step();
    reset = 1'b1;
    clear_counts();
    repeat (6) step();
    check("reset_press_all", 32'(np[11] + np[0]), 32'd2);
    settle();

    // clean press and release on channel 7, no lockout
    clear_counts();
    raw_in[7] = 1'b1;
    repeat (5) step();
    raw_in[7] = 1'b0;
    repeat (6) step();
    check("clean_press_cnt", 32'(np[7]), 32'd1);
    check("clean_release_cnt", 32'(nr[7]), 32'd1);
    settle();

    // bouncing press on channel 3
    debounce_limit = 23'd10;
    clear_counts();
    raw_in[3] = 1'b1; step();
    raw_in[3] = 1'b0; step();
    raw_in[3] = 1'b1; step();
    raw_in[3] = 1'b0; step();
    raw_in[3] = 1'b1;
    repeat (20) step();
    check("bounce_press_cnt", 32'(np[3]), 32'd1);
    check("bounce_release_cnt", 32'(nr[3]), 32'd0);
    settle();

    // re-press during cooldown, then again well after it
    debounce_limit = 23'd8;
    clear_counts();
    raw_in[0] = 1'b1;
    repeat (15) step();
    raw_in[0] = 1'b0;
    repeat (3) step();
    check("cooldown_release_seen", 32'(nr[0]), 32'd1);
    repeat (4) step();
    raw_in[0] = 1'b1;
    repeat (20) step();
    check("cooldown_press_cnt", 32'(np[0]), 32'd2);
    raw_in[0] = 1'b0;
    repeat (23) step();
    raw_in[0] = 1'b1;
    repeat (5) step();
    check("late_press_cnt", 32'(np[0]), 32'd3);
    settle();

    // simultaneous presses on three channels
    debounce_limit = 23'd0;
    raw_in = 12'b1000_0010_0001;
    repeat (5) step();
    settle();

    // random toggling under several lockout lengths
    for (int r = 0; r < 4; r++) begin
      debounce_limit = CNT_W'($urandom_range(0, 6));
      repeat (60) begin
        for (int c = 0; c < NUM_CH; c++)
          if ($urandom_range(0, 3) == 0) raw_in[c] = ~raw_in[c];
        step();
      end
      settle();
    end

    // reset in the middle of activity
    raw_in = 12'(($urandom() & 32'h0000_0fff) | 32'h1);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (6) step();
    settle();

`ifdef INPUT_COND_AUTOREPEAT_EN
    // held key produces repeat pulses
    debounce_limit = 23'd0;
    clear_counts();
    raw_in[2] = 1'b1;
    repeat (40) step();
    raw_in[2] = 1'b0;
    repeat (10) step();
    check("repeat_press_cnt", 32'(np[2]), 32'd5);
    check("repeat_release_cnt", 32'(nr[2]), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised N-channel front end for push-button and switch inputs. Per channel it provides:
- a metastability synchroniser,
- a debounced level,
- single-cycle press and release pulses,
- debounce lockout after both press and release, with a runtime-programmable lockout length.

It sits between the top-level input pins and the game logic (turn ownership, PvE, debug select). It replaces the ad-hoc per-signal synchronisers and the single-channel confirm one-shot.

Parameters:
NUM_CH, 12, number of independent input channels
SYNC_STAGES, 2, flip-flop stages in each synchroniser (legal values 2..4)
CNT_W, 23, width of the per-channel lockout counter and of debounce_limit
REPEAT_DELAY, 25_000_000, cycles held before auto-repeat starts (only with INPUT_COND_AUTOREPEAT_EN)
REPEAT_PERIOD, 6_250_000, cycles between auto-repeat pulses (only with INPUT_COND_AUTOREPEAT_EN)

Ports:
clock  input  1  system clock (single clock domain)
reset  input  1  synchronous, active-low reset
raw_in  input  NUM_CH  asynchronous button/switch pins
debounce_limit  input  CNT_W  lockout length in cycles; 6_250_000 on FPGA/chip, 0 in cocotb
level  output  NUM_CH  debounced, synchronised level
press  output  NUM_CH  one-cycle pulse on accepted press
release  output  NUM_CH  one-cycle pulse on accepted release
any_press  output  1  OR of press, same cycle

Behaviour:
- One clock; reset is synchronous and active-low (reset==0 at a clock edge resets everything).
- Reset values:
  - synchroniser flops 0;
  - every channel FSM in IDLE;
  - counters 0;
  - level, press, release, any_press all 0.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops to give s[i]. Reset mid-operation clears the chain.
- Per-channel FSM, all outputs registered:
  - IDLE: level=0. If s=1, go to PRESSED.
  - PRESSED: press=1, level=1, counter cleared. Lasts exactly 1 cycle, then go to HELD.
  - HELD: level=1. Counter increments each cycle and saturates at debounce_limit. When s=0 and counter>=debounce_limit, go to RELEASED; otherwise stay.
  - RELEASED: release=1, level=0, counter cleared. Lasts exactly 1 cycle, then go to COOLDOWN.
  - COOLDOWN: level=0. Counter increments and saturates. When counter>=debounce_limit, go to IDLE regardless of s. A press still held on exit is accepted on the next cycle via IDLE then PRESSED.
- Latency with SYNC_STAGES=2: raw rises before edge k; s is high after edge k+1; state is PRESSED after edge k+2. press is high for the one cycle following edge k+2. Release timing is symmetric.
- Bounces during HELD or COOLDOWN produce no pulses.
- debounce_limit=0:
  - HELD exits on the first cycle with s=0;
  - COOLDOWN lasts 1 cycle.
- debounce_limit is sampled every cycle. Changing it mid-lockout uses the new value immediately. Lowering it below the current count ends the lockout on that cycle.
- Counter width: CNT_W bits. The counter never wraps; it saturates at debounce_limit.
- Channels are fully independent. Simultaneous presses on several channels each pulse in the same cycle, and any_press=1 for that cycle.
- press and release are never both 1 on the same channel in the same cycle.

Optional Feature:
Macro: INPUT_COND_AUTOREPEAT_EN.
- Defined: in HELD, with s still 1, a repeat counter runs from PRESSED.
  - After REPEAT_DELAY cycles, emit press for 1 cycle.
  - Then emit press every REPEAT_PERIOD cycles until s=0.
  - The repeat counter is cleared on leaving HELD.
  - Repeat pulses also drive any_press.
- Not defined: none of this logic exists; HELD emits no pulses.

Decomposition:
- Package input_cond_pkg holds:
  - enum cond_state_t {IDLE, PRESSED, HELD, RELEASED, COOLDOWN};
  - the FPGA default lockout constant DEBOUNCE_LIMIT_FPGA = 23'd6_250_000.
- One sub-module, input_cond_channel: synchroniser, FSM and counter for a single channel. It is instantiated NUM_CH times in a generate loop. The top module only ORs the press outputs into any_press.

Test Plan:
- Reset: hold reset=0 for 3 cycles with raw_in all 1 -> all outputs 0; after release, press on every channel 3 cycles later.
- Clean press, limit=0, raw[7] high 5 cycles then low -> press[7] exactly 1 cycle, 3 cycles after the rise; level[7] high; release[7] 1 cycle, 3 cycles after the fall.
- Bounce, limit=10: raw[3] toggles 1,0,1,0,1 on consecutive cycles then stays 1 -> exactly one press pulse, no release pulse.
- Cooldown, limit=8: release raw[0], then press again 4 cycles after the release pulse -> press delayed until COOLDOWN ends. Press again after 20 cycles -> normal 3-cycle latency.
- Simultaneous presses: raw[0], raw[5], raw[11] rise on the same edge -> the three press bits and any_press are high in the same single cycle.
- Autorepeat with INPUT_COND_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold raw[2] for 40 cycles -> initial press, then repeat pulses 20, 25, 30, 35 cycles after it, then one release.
